sid_write_queue: RTL and testbench

SID_WRITE_QUEUE -- requirements
Module: sid_write_queue

---
 rtl/sid_pkg.sv | 31 +++
 rtl/sid_fifo.sv | 58 +++++
 rtl/sid_write_queue.sv | 112 +++++++++++
 tb/tb_sid_write_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared widths, entry layout and decoder state encoding for the SID write queue.
package sid_pkg;

  localparam int SID_ADDR_W  = 5;
  localparam int SID_DATA_W  = 8;
  localparam int SID_HDR_BIT = 7;
  localparam int SID_ENTRY_W = SID_ADDR_W + SID_DATA_W;

  typedef struct packed {
    logic [SID_ADDR_W-1:0] addr;
    logic [SID_DATA_W-1:0] data;
  } sid_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HDR  = 1'b1
  } sid_state_e;

  // Merge the latched header fields with the low six bits of a data byte.
  function automatic logic [SID_ENTRY_W-1:0] sid_make_entry(
    input logic [SID_ADDR_W-1:0] addr,
    input logic [1:0]            dhi,
    input logic [7:0]            b
  );
    sid_entry_t e;
    e.addr = addr;
    e.data = {dhi, b[5:0]};
    return e;
  endfunction

endpackage

// File: rtl/sid_fifo.sv
// Single-clock FIFO holding decoded SID register writes; a push is accepted
// when full only if a pop happens in the same cycle.
module sid_fifo
  import sid_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [SID_ENTRY_W-1:0]   wdata,
  output logic [SID_ENTRY_W-1:0]   rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

  logic [SID_ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [PTR_W:0]         level_r;
  logic                   push_ok_s;
  logic                   pop_ok_s;

  assign full      = (level_r == LVL_FULL);
  assign empty     = (level_r == {(PTR_W+1){1'b0}});
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/sid_write_queue.sv
// Decodes header/data byte pairs from the SPI slave into SID register writes
// and replays them one per SID clock enable.
module sid_write_queue
  import sid_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             iData,
  input  logic                   iRecv,
  input  logic                   iClkEn,
  output logic                   oWE,
  output logic [4:0]             oAddr,
  output logic [7:0]             oDataW,
  output logic [$clog2(DEPTH):0] oLevel,
  output logic                   oOverflow,
  output logic                   oProtoErr
);

  sid_state_e             state_r;
  sid_state_e             state_nxt_s;
  logic [SID_ADDR_W-1:0]  hdr_addr_r;
  logic [1:0]             hdr_dhi_r;
  logic                   is_hdr_s;
  logic                   push_s;
  logic                   proto_err_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   empty_s;
  logic [SID_ENTRY_W-1:0] wdata_s;
  sid_entry_t             rdata_s;

  assign is_hdr_s = iData[SID_HDR_BIT];
  assign wdata_s  = sid_make_entry(hdr_addr_r, hdr_dhi_r, iData);
  // Eligibility uses the registered level, so a same-cycle push never pops.
  assign pop_s    = iClkEn & ~empty_s;

  sid_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .level (oLevel),
    .full  (full_s),
    .empty (empty_s)
  );

  // Decoder state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Decoder next state: headers always arm, data always disarms.
  always_comb begin
    state_nxt_s = state_r;
    if (iRecv) begin
      if (is_hdr_s) state_nxt_s = HDR;
      else          state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Decoder outputs: data byte pushes when armed, flags a protocol error otherwise.
  always_comb begin
    push_s      = 1'b0;
    proto_err_s = 1'b0;
    case (state_r)
      HDR:     push_s      = iRecv & ~is_hdr_s;
      IDLE:    proto_err_s = iRecv & ~is_hdr_s;
      default: begin
        push_s      = 1'b0;
        proto_err_s = 1'b0;
      end
    endcase
  end

  // Header field latch; a new header simply overwrites a pending one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_addr_r <= {SID_ADDR_W{1'b0}};
      hdr_dhi_r  <= 2'b00;
    end else if (iRecv && is_hdr_s) begin
      hdr_addr_r <= iData[6:2];
      hdr_dhi_r  <= iData[1:0];
    end
  end

  // Write port register and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oWE       <= 1'b0;
      oAddr     <= 5'd0;
      oDataW    <= 8'd0;
      oOverflow <= 1'b0;
      oProtoErr <= 1'b0;
    end else begin
      oWE <= pop_s;
      if (pop_s) begin
        oAddr  <= rdata_s.addr;
        oDataW <= rdata_s.data;
      end
      if (push_s && full_s && !pop_s) oOverflow <= 1'b1;
      if (proto_err_s)                oProtoErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sid_write_queue.sv
// Bench for sid_write_queue: table-driven byte pairs plus hand-written
// overflow, full push/pop and mid-sequence reset sequences, with a scoreboard.
module tb_sid_write_queue;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] iData;
  logic       iRecv;
  logic       iClkEn;
  logic       oWE;
  logic [4:0] oAddr;
  logic [7:0] oDataW;
  logic [4:0] oLevel;
  logic       oOverflow;
  logic       oProtoErr;

  int n_vec  = 0;
  int n_err  = 0;
  int wr_cnt = 0;
  logic [12:0] sb[$];

  typedef struct {
    logic       pre_v;
    logic [7:0] pre;
    logic [7:0] hdr;
    logic [7:0] dat;
    logic [4:0] ea;
    logic [7:0] ed;
  } vec_t;

  vec_t vt[6];

  sid_write_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .iData     (iData),
    .iRecv     (iRecv),
    .iClkEn    (iClkEn),
    .oWE       (oWE),
    .oAddr     (oAddr),
    .oDataW    (oDataW),
    .oLevel    (oLevel),
    .oOverflow (oOverflow),
    .oProtoErr (oProtoErr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (oWE === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    iData = b;
    iRecv = 1'b1;
    tick();
    iRecv = 1'b0;
    iData = 8'h00;
  endtask

  task automatic pulse_en();
    iClkEn = 1'b1;
    tick();
    iClkEn = 1'b0;
  endtask

  task automatic expect_write(input string nm);
    logic [12:0] e;
    chk({nm, "_we"}, {31'd0, oWE}, 32'd1);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_sb: got write 0x%0h/0x%0h, expected none", nm, oAddr, oDataW);
    end else begin
      e = sb.pop_front();
      chk({nm, "_addr"}, {27'd0, oAddr}, {27'd0, e[12:8]});
      chk({nm, "_data"}, {24'd0, oDataW}, {24'd0, e[7:0]});
    end
  endtask

  task automatic drain(input string nm, input int n);
    for (int k = 0; k < n; k++) begin
      pulse_en();
      expect_write(nm);
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    tick();
  endtask

  initial begin
    int w0;
    logic [7:0] h;
    logic [7:0] d;

    vt[0] = '{1'b0, 8'h00, 8'h86, 8'h15, 5'h01, 8'h95};
    vt[1] = '{1'b1, 8'hFC, 8'h87, 8'h3F, 5'h01, 8'hFF};
    vt[2] = '{1'b0, 8'h00, 8'hFF, 8'h7F, 5'h1F, 8'hFF};
    vt[3] = '{1'b0, 8'h00, 8'h80, 8'h40, 5'h00, 8'h00};
    vt[4] = '{1'b0, 8'h00, 8'hA9, 8'h2C, 5'h0A, 8'h6C};
    vt[5] = '{1'b0, 8'h00, 8'hC2, 8'h55, 5'h10, 8'h95};

    rst = 1'b1; iRecv = 1'b0; iClkEn = 1'b0; iData = 8'h00;
    tick();
    tick();
    chk("rst_we",    {31'd0, oWE},       32'd0);
    chk("rst_addr",  {27'd0, oAddr},     32'd0);
    chk("rst_data",  {24'd0, oDataW},    32'd0);
    chk("rst_level", {27'd0, oLevel},    32'd0);
    chk("rst_ovf",   {31'd0, oOverflow}, 32'd0);
    chk("rst_perr",  {31'd0, oProtoErr}, 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      w0 = wr_cnt;
      if (vt[v].pre_v) send(vt[v].pre);
      send(vt[v].hdr);
      chk("tbl_lvl_hdr", {27'd0, oLevel}, 32'd0);
      send(vt[v].dat);
      chk("tbl_lvl_push", {27'd0, oLevel}, 32'd1);
      sb.push_back({vt[v].ea, vt[v].ed});
      pulse_en();
      expect_write("tbl");
      chk("tbl_lvl_pop", {27'd0, oLevel}, 32'd0);
      tick();
      chk("tbl_we_low", {31'd0, oWE}, 32'd0);
      chk("tbl_addr_hold", {27'd0, oAddr}, {27'd0, vt[v].ea});
      chk("tbl_wr_cnt", wr_cnt - w0, 32'd1);
    end
    chk("tbl_perr_clean", {31'd0, oProtoErr}, 32'd0);

    // Data byte with no pending header.
    send(8'h2A);
    chk("perr_set", {31'd0, oProtoErr}, 32'd1);
    chk("perr_lvl", {27'd0, oLevel}, 32'd0);
    pulse_en();
    chk("perr_no_we", {31'd0, oWE}, 32'd0);
    tick();

    // Push on an enable cycle with an empty FIFO must not pop that cycle.
    send(8'h86);
    iData = 8'h15; iRecv = 1'b1; iClkEn = 1'b1;
    tick();
    iRecv = 1'b0; iClkEn = 1'b0; iData = 8'h00;
    chk("samecyc_no_we", {31'd0, oWE}, 32'd0);
    chk("samecyc_lvl", {27'd0, oLevel}, 32'd1);
    sb.push_back({5'h01, 8'h95});
    pulse_en();
    expect_write("samecyc");
    tick();

    // Seventeen pairs with no enable: the last is dropped.
    for (int i = 1; i <= 17; i++) begin
      h = {1'b1, i[4:0], 2'b00};
      d = {2'b00, i[5:0]};
      send(h);
      send(d);
      if (i <= 16) sb.push_back({i[4:0], 2'b00, i[5:0]});
      if (i == 16) begin
        chk("ovf_lvl16", {27'd0, oLevel}, 32'd16);
        chk("ovf_not_yet", {31'd0, oOverflow}, 32'd0);
      end
    end
    chk("ovf_lvl_full", {27'd0, oLevel}, 32'd16);
    chk("ovf_set", {31'd0, oOverflow}, 32'd1);
    chk("perr_sticky", {31'd0, oProtoErr}, 32'd1);
    drain("ovf_pop", 16);
    chk("ovf_lvl_empty", {27'd0, oLevel}, 32'd0);
    pulse_en();
    chk("ovf_17th_absent", {31'd0, oWE}, 32'd0);
    chk("ovf_sticky", {31'd0, oOverflow}, 32'd1);
    tick();

    // Full FIFO with a push coinciding with a pop.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      h = {1'b1, i[4:0], 2'b01};
      d = {2'b00, i[5:0]};
      send(h);
      send(d);
      sb.push_back({i[4:0], 2'b01, i[5:0]});
    end
    chk("full_lvl", {27'd0, oLevel}, 32'd16);
    send(8'hD0);
    sb.push_back({5'h14, 8'h3C});
    iData = 8'h3C; iRecv = 1'b1; iClkEn = 1'b1;
    tick();
    iRecv = 1'b0; iClkEn = 1'b0; iData = 8'h00;
    expect_write("full_pp");
    chk("full_pp_lvl", {27'd0, oLevel}, 32'd16);
    chk("full_pp_ovf", {31'd0, oOverflow}, 32'd0);
    tick();
    drain("full_drain", 16);
    chk("full_drain_lvl", {27'd0, oLevel}, 32'd0);
    chk("full_drain_sb", sb.size(), 32'd0);

    // Reset mid-sequence with a header latched and three entries queued.
    send(8'h2A);
    for (int i = 0; i < 3; i++) begin
      send(8'h86);
      send(8'h15);
    end
    send(8'h86);
    pulse_en();
    chk("mid_lvl3", {27'd0, oLevel}, 32'd2);
    chk("mid_we", {31'd0, oWE}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we",    {31'd0, oWE},       32'd0);
    chk("arst_addr",  {27'd0, oAddr},     32'd0);
    chk("arst_data",  {24'd0, oDataW},    32'd0);
    chk("arst_level", {27'd0, oLevel},    32'd0);
    chk("arst_perr",  {31'd0, oProtoErr}, 32'd0);
    tick();
    rst = 1'b0;
    sb.delete();
    w0 = wr_cnt;
    send(8'h15);
    chk("post_rst_perr", {31'd0, oProtoErr}, 32'd1);
    chk("post_rst_lvl", {27'd0, oLevel}, 32'd0);
    pulse_en();
    chk("post_rst_no_we", {31'd0, oWE}, 32'd0);
    tick();
    chk("post_rst_wr_cnt", wr_cnt - w0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
